axi4lite_reg_slave: RTL and testbench

//  AXI4-Lite subordinate: active responder end of the interface our AXI4-Lite checker monitors.

---
 rtl/axi4lite_pkg.sv | 22 ++
 rtl/axi4lite_reg_slave_if.sv | 43 ++++
 rtl/axi4lite_reg_bank.sv | 40 ++++
 rtl/axi4lite_reg_slave.sv | 213 +++++++++++++++++++++
 tb/tb_axi4lite_reg_slave.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite response codes and channel FSM state types for the register slave.
// Build option AXI4LITE_SLV_DECERR_EN is consumed in axi4lite_reg_slave.sv.
package axi4lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_HAVE_AW = 2'd1,
    W_HAVE_W  = 2'd2,
    W_RESP    = 2'd3
  } wr_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_t;

endpackage

// File: rtl/axi4lite_reg_slave_if.sv
// AXI4-Lite bus bundle (AW/W/B/AR/R) with master and slave views.
// Handshake rule on every channel: a transfer happens on the rising edge where VALID and READY
// are both 1; VALID, once raised, and its payload stay constant until that edge.
interface axi4lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]              AWPROT;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]              ARPROT;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport slave (
    input  AWADDR, AWPROT, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WVALID,    output WREADY,
    output BRESP, BVALID,           input  BREADY,
    input  ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID,    input  RREADY
  );

  modport master (
    output AWADDR, AWPROT, AWVALID, input  AWREADY,
    output WDATA, WSTRB, WVALID,    input  WREADY,
    input  BRESP, BVALID,           output BREADY,
    output ARADDR, ARPROT, ARVALID, input  ARREADY,
    input  RDATA, RRESP, RVALID,    output RREADY
  );
endinterface

// File: rtl/axi4lite_reg_bank.sv
// Register storage: NUM_REGS words, one byte-strobed write port, one combinational read port.
module axi4lite_reg_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        we,
  input  logic [$clog2(NUM_REGS)-1:0] widx,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic [DATA_WIDTH/8-1:0]     wstrb,
  input  logic [$clog2(NUM_REGS)-1:0] ridx,
  output logic [DATA_WIDTH-1:0]       rdata
);
  localparam int STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) regs_d[widx][8*b +: 8] = wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read sees the pre-edge contents, so a same-edge commit is not visible to it.
  assign rdata = regs_q[ridx];

endmodule

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite register slave: independent write (AW/W/B) and read (AR/R) FSMs over a register bank.
// Define AXI4LITE_SLV_DECERR_EN to answer DECERR for addresses with bits set above the index field.
module axi4lite_reg_slave
  import axi4lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic      ACLK,
  input  logic      ARESETn,
  axi4lite_if.slave s_axi,
  output wr_state_t wr_state_dbg,
  output rd_state_t rd_state_dbg
);
  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int IDX_W    = $clog2(NUM_REGS);
  localparam int ADDR_LSB = $clog2(STRB_W);
`ifdef AXI4LITE_SLV_DECERR_EN
  localparam logic DECERR_EN = 1'b1;
`else
  localparam logic DECERR_EN = 1'b0;
`endif

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
    $error("axi4lite_reg_slave: DATA_WIDTH must be 32 or 64");
  end
  if (NUM_REGS < 2 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_num_regs
    $error("axi4lite_reg_slave: NUM_REGS must be a power of 2 and >= 2");
  end

  function automatic logic addr_err(input logic [ADDR_WIDTH-1:0] a);
    return DECERR_EN && (|(a >> (ADDR_LSB + IDX_W)));
  endfunction

  wr_state_t             wr_state_q, wr_state_d;
  logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_data;
  logic [STRB_W-1:0]     c_strb;
  logic                  aw_hs, w_hs;

  rd_state_t             rd_state_q, rd_state_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, bank_rdata;
  logic                  ar_hs;
  logic                  unused_prot;

  assign aw_hs = s_axi.AWVALID && awready_q;
  assign w_hs  = s_axi.WVALID && wready_q;
  assign ar_hs = s_axi.ARVALID && arready_q;
  assign unused_prot = ^{s_axi.AWPROT, s_axi.ARPROT};

  // The commit happens on the edge completing the second of AW/W, taking the live channel
  // for whichever half arrives last.
  always_comb begin
    wr_state_d = wr_state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    commit     = 1'b0;
    c_addr     = s_axi.AWADDR;
    c_data     = s_axi.WDATA;
    c_strb     = s_axi.WSTRB;
    case (wr_state_q)
      W_IDLE: begin
        awready_d = 1'b1;
        wready_d  = 1'b1;
        if (aw_hs && w_hs) begin
          commit    = 1'b1;
          awready_d = 1'b0;
          wready_d  = 1'b0;
        end else if (aw_hs) begin
          awaddr_d   = s_axi.AWADDR;
          awready_d  = 1'b0;
          wr_state_d = W_HAVE_AW;
        end else if (w_hs) begin
          wdata_d    = s_axi.WDATA;
          wstrb_d    = s_axi.WSTRB;
          wready_d   = 1'b0;
          wr_state_d = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        if (w_hs) begin
          commit   = 1'b1;
          c_addr   = awaddr_q;
          wready_d = 1'b0;
        end
      end
      W_HAVE_W: begin
        if (aw_hs) begin
          commit    = 1'b1;
          c_data    = wdata_q;
          c_strb    = wstrb_q;
          awready_d = 1'b0;
        end
      end
      W_RESP: begin
        if (s_axi.BREADY) begin
          bvalid_d   = 1'b0;
          bresp_d    = RESP_OKAY;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
    if (commit) begin
      bvalid_d   = 1'b1;
      bresp_d    = addr_err(c_addr) ? RESP_DECERR : RESP_OKAY;
      wr_state_d = W_RESP;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    case (rd_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          rresp_d    = addr_err(s_axi.ARADDR) ? RESP_DECERR : RESP_OKAY;
          rdata_d    = addr_err(s_axi.ARADDR) ? '0 : bank_rdata;
          rd_state_d = R_RESP;
        end
      end
      R_RESP: begin
        if (s_axi.RREADY) begin
          rvalid_d   = 1'b0;
          rresp_d    = RESP_OKAY;
          arready_d  = 1'b1;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
    end
  end

  axi4lite_reg_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_REGS  (NUM_REGS)
  ) u_bank (
    .clk  (ACLK),
    .rst_n(ARESETn),
    .we   (commit && !addr_err(c_addr)),
    .widx (c_addr[ADDR_LSB +: IDX_W]),
    .wdata(c_data),
    .wstrb(c_strb),
    .ridx (s_axi.ARADDR[ADDR_LSB +: IDX_W]),
    .rdata(bank_rdata)
  );

  assign s_axi.AWREADY = awready_q;
  assign s_axi.WREADY  = wready_q;
  assign s_axi.BVALID  = bvalid_q;
  assign s_axi.BRESP   = bresp_q;
  assign s_axi.ARREADY = arready_q;
  assign s_axi.RVALID  = rvalid_q;
  assign s_axi.RRESP   = rresp_q;
  assign s_axi.RDATA   = rdata_q;
  assign wr_state_dbg  = wr_state_q;
  assign rd_state_dbg  = rd_state_q;

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Bench for axi4lite_reg_slave: directed vector table, hand-written corner sequences and
// random traffic checked against an array model of the register file.
module tb_axi4lite_reg_slave;
  import axi4lite_pkg::*;

  localparam int TMO = 50;
`ifdef AXI4LITE_SLV_DECERR_EN
  localparam logic DEC_EN = 1'b1;
`else
  localparam logic DEC_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi4lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  wr_state_t wr_dbg;
  rd_state_t rd_dbg;

  axi4lite_reg_slave #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .NUM_REGS  (16)
  ) dut (
    .ACLK        (clk),
    .ARESETn     (rst_n),
    .s_axi       (bus),
    .wr_state_dbg(wr_dbg),
    .rd_state_dbg(rd_dbg)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  logic [31:0] model_regs [16];

  function automatic logic m_err(input logic [31:0] a);
    return DEC_EN && (a[31:6] != 26'd0);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'(a[5:2]);
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (!m_err(a)) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) model_regs[m_idx(a)][8*b +: 8] = d[8*b +: 8];
      end
    end
  endtask

  // ---------------- scoreboard check ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly,
                          output logic [1:0] resp);
    logic [1:0] r0;
    logic       stable;
    int         g;
    fork
      begin
        int ga;
        repeat (aw_dly) begin @(posedge clk); #1; end
        bus.AWADDR  = addr;
        bus.AWVALID = 1'b1;
        ga = 0;
        while (bus.AWREADY !== 1'b1 && ga < TMO) begin @(posedge clk); #1; ga++; end
        if (ga >= TMO) chk("aw_timeout", bus.AWREADY, 1);
        else begin
          @(posedge clk); #1;
          chk("awready_drop", bus.AWREADY, 0);
        end
        bus.AWVALID = 1'b0;
      end
      begin
        int gw;
        repeat (w_dly) begin @(posedge clk); #1; end
        bus.WDATA  = data;
        bus.WSTRB  = strb;
        bus.WVALID = 1'b1;
        gw = 0;
        while (bus.WREADY !== 1'b1 && gw < TMO) begin @(posedge clk); #1; gw++; end
        if (gw >= TMO) chk("w_timeout", bus.WREADY, 1);
        else begin
          @(posedge clk); #1;
          chk("wready_drop", bus.WREADY, 0);
        end
        bus.WVALID = 1'b0;
      end
    join
    g = 0;
    while (bus.BVALID !== 1'b1 && g < TMO) begin @(posedge clk); #1; g++; end
    chk("bvalid_latency", g, 0);
    r0 = bus.BRESP;
    stable = 1'b1;
    repeat (b_dly) begin
      @(posedge clk); #1;
      if (bus.BVALID !== 1'b1 || bus.BRESP !== r0 || bus.AWREADY !== 1'b0 || bus.WREADY !== 1'b0)
        stable = 1'b0;
    end
    if (b_dly > 0) chk("b_stall_stable", stable, 1);
    resp = r0;
    bus.BREADY = 1'b1;
    @(posedge clk); #1;
    bus.BREADY = 1'b0;
    chk("ready_after_b", {bus.BVALID, bus.AWREADY, bus.WREADY}, 3'b011);
  endtask

  task automatic do_read(input logic [31:0] addr, input int r_dly,
                         output logic [31:0] data, output logic [1:0] resp);
    logic [31:0] d0;
    logic [1:0]  r0;
    logic        stable;
    int          g;
    bus.ARADDR  = addr;
    bus.ARVALID = 1'b1;
    g = 0;
    while (bus.ARREADY !== 1'b1 && g < TMO) begin @(posedge clk); #1; g++; end
    if (g >= TMO) begin
      chk("ar_timeout", bus.ARREADY, 1);
      bus.ARVALID = 1'b0;
      data = '0;
      resp = '0;
      return;
    end
    @(posedge clk); #1;
    bus.ARVALID = 1'b0;
    chk("rvalid_after_ar", {bus.RVALID, bus.ARREADY}, 2'b10);
    d0 = bus.RDATA;
    r0 = bus.RRESP;
    stable = 1'b1;
    repeat (r_dly) begin
      @(posedge clk); #1;
      if (bus.RVALID !== 1'b1 || bus.RDATA !== d0 || bus.RRESP !== r0 || bus.ARREADY !== 1'b0)
        stable = 1'b0;
    end
    if (r_dly > 0) chk("r_stall_stable", stable, 1);
    data = d0;
    resp = r0;
    bus.RREADY = 1'b1;
    @(posedge clk); #1;
    bus.RREADY = 1'b0;
    chk("arready_after_r", {bus.RVALID, bus.ARREADY}, 2'b01);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    logic [31:0] raddr;
    int          r_dly;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [31:0] rd;
    logic [1:0]  rr, br;
    logic [31:0] a, d;
    logic [3:0]  s;

    vecs[0] = '{32'h08, 32'hDEADBEEF, 4'hF,   0, 0,  0, 32'h08,  0, 32'hDEADBEEF};
    vecs[1] = '{32'h08, 32'h0000AB00, 4'h2,   3, 0,  0, 32'h08,  0, 32'hDEADABEF};
    vecs[2] = '{32'h04, 32'h12345678, 4'h1,   0, 2,  0, 32'h04,  0, 32'h00000078};
    vecs[3] = '{32'h04, 32'hAABBCCDD, 4'hC,   0, 0, 10, 32'h04, 10, 32'hAABB0078};
    vecs[4] = '{32'h3C, 32'hFFFFFFFF, 4'h0,   1, 1,  0, 32'h3C,  0, 32'h00000000};
    vecs[5] = '{32'h3F, 32'h11223344, 4'hF,   0, 0,  1, 32'h3C,  2, 32'h11223344};
    vecs[6] = '{32'h0B, 32'h00C0FFEE, 4'h5,   0, 0,  0, 32'h09,  0, 32'hDEC0ABEE};

    for (int i = 0; i < 16; i++) model_regs[i] = '0;
    bus.AWADDR = '0; bus.AWPROT = '0; bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
    bus.ARADDR = '0; bus.ARPROT = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;

    // Reset state and readies one edge after release
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {bus.AWREADY, bus.WREADY, bus.ARREADY, bus.BVALID, bus.RVALID,
                          bus.BRESP, bus.RRESP, bus.RDATA}, 64'd0);
    chk("reset_states", {wr_dbg, rd_dbg}, {W_IDLE, R_IDLE});
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("readies_after_release", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      do_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb,
               vecs[i].aw_dly, vecs[i].w_dly, vecs[i].b_dly, br);
      model_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb);
      chk($sformatf("vec%0d_bresp", i), br, RESP_OKAY);
      do_read(vecs[i].raddr, vecs[i].r_dly, rd, rr);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_rresp", i), rr, RESP_OKAY);
    end

    // Same-edge AR and AW+W to one index returns the old value
    do_write(32'h10, 32'h1, 4'hF, 0, 0, 0, br);
    model_write(32'h10, 32'h1, 4'hF);
    fork
      do_write(32'h10, 32'h2, 4'hF, 0, 0, 0, br);
      do_read(32'h10, 0, rd, rr);
    join
    model_write(32'h10, 32'h2, 4'hF);
    chk("same_edge_old_value", rd, 32'h1);
    do_read(32'h10, 0, rd, rr);
    chk("same_edge_new_value", rd, 32'h2);

    // Out-of-range address: DECERR when enabled, alias of reg 0 otherwise
    do_write(32'h0, 32'h0A0B0C0D, 4'hF, 0, 0, 0, br);
    model_write(32'h0, 32'h0A0B0C0D, 4'hF);
    do_write(32'h1000, 32'hFFFFFFFF, 4'hF, 0, 0, 0, br);
    model_write(32'h1000, 32'hFFFFFFFF, 4'hF);
    chk("hi_addr_bresp", br, DEC_EN ? RESP_DECERR : RESP_OKAY);
    do_read(32'h1000, 0, rd, rr);
    chk("hi_addr_rresp", rr, DEC_EN ? RESP_DECERR : RESP_OKAY);
    chk("hi_addr_rdata", rd, DEC_EN ? 32'h0 : 32'hFFFFFFFF);
    do_read(32'h0, 0, rd, rr);
    chk("hi_addr_reg0", rd, DEC_EN ? 32'h0A0B0C0D : 32'hFFFFFFFF);

    // Random traffic against the model
    for (int n = 0; n < 150; n++) begin
      a = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) a[$urandom_range(6, 31)] = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        do_write(a, d, s, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), br);
        model_write(a, d, s);
        chk("rand_bresp", br, m_err(a) ? RESP_DECERR : RESP_OKAY);
      end else begin
        do_read(a, $urandom_range(0, 2), rd, rr);
        chk("rand_rdata", rd, m_err(a) ? 32'h0 : model_regs[m_idx(a)]);
        chk("rand_rresp", rr, m_err(a) ? RESP_DECERR : RESP_OKAY);
      end
    end

    // Reset while a write response is pending
    bus.AWADDR = 32'h08; bus.AWVALID = 1'b1;
    bus.WDATA = 32'h55AA55AA; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    @(posedge clk); #1;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    chk("pending_b_before_reset", bus.BVALID, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("reset_drops_valids", {bus.BVALID, bus.RVALID, bus.AWREADY, bus.WREADY, bus.ARREADY}, 5'b0);
    for (int i = 0; i < 16; i++) model_regs[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("readies_after_reset", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 3'b111);
    do_read(32'h08, 0, rd, rr);
    chk("reg2_cleared", rd, model_regs[2]);
    do_read(32'h10, 0, rd, rr);
    chk("reg4_cleared", rd, model_regs[4]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
